dcache_tag_tracker: RTL

//  Parametrised outstanding-request tracker between the core memory pipeline and the HPDC request/response ports.

---
 rtl/dcache_tag_tracker_if.sv | 38 +++
 rtl/dcache_tag_tracker.sv | 119 +++++++++++
 2 files changed

// File: rtl/dcache_tag_tracker_if.sv
// Core/HPDC request-response bundle seen by the outstanding-request tracker.
// The tracker sits on the slave modport. The environment that drives the core
// and HPDC side sits on the master modport.
interface dcache_tag_tracker_if #(
    parameter int unsigned TAG_W        = 7,
    parameter int unsigned MAX_INFLIGHT = 16
);
    localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);

    logic             req_valid_i;
    logic [TAG_W-1:0] req_tag_i;
    logic             dcache_ready_i;
    logic             core_req_valid_o;
    logic             core_ready_o;
    logic             rsp_valid_i;
    logic [TAG_W-1:0] rsp_tag_i;
    logic             wbuf_empty_i;
    logic             fence_i;
    logic             fence_done_o;
    logic [CNT_W-1:0] inflight_cnt_o;
    logic             stall_o;
    logic             err_spurious_rsp_o;
    logic             timeout_o;

    modport slave (
        input  req_valid_i, req_tag_i, dcache_ready_i, rsp_valid_i, rsp_tag_i,
        input  wbuf_empty_i, fence_i,
        output core_req_valid_o, core_ready_o, fence_done_o, inflight_cnt_o,
        output stall_o, err_spurious_rsp_o, timeout_o
    );

    modport master (
        output req_valid_i, req_tag_i, dcache_ready_i, rsp_valid_i, rsp_tag_i,
        output wbuf_empty_i, fence_i,
        input  core_req_valid_o, core_ready_o, fence_done_o, inflight_cnt_o,
        input  stall_o, err_spurious_rsp_o, timeout_o
    );
endinterface

// File: rtl/dcache_tag_tracker.sv
// Outstanding-request tracker between the core memory pipeline and the HPDC.
// It keeps a per-tag pending table and a bounded in-flight counter.
// It also runs a fence/drain FSM and a response watchdog.
// A request is gated while its tag is pending, while the tracker is full,
// or while a fence is in progress.
module dcache_tag_tracker #(
    parameter int unsigned TAG_W          = 7,
    parameter int unsigned MAX_INFLIGHT   = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = $clog2(MAX_INFLIGHT + 1)
) (
    input logic                  clk_i,
    input logic                  rst_i,
    dcache_tag_tracker_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** TAG_W;
    localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StDrain, StDone} state_e;

    logic [DEPTH-1:0] pending_q, pending_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   cnt_ext;
    logic [WD_W-1:0]  wdog_q, wdog_d;
    state_e           state_q;
    logic             fence_done_q;
    logic             err_q;
    logic             timeout_q;
    logic             stall, send, recv_ok, spurious;

    // Stall decode and gated handshake; all stall reasons come from registered state.
    always_comb begin
        stall = pending_q[bus.req_tag_i]
              | (cnt_q == CNT_W'(MAX_INFLIGHT))
              | (state_q != StIdle);
        bus.stall_o          = bus.req_valid_i & stall;
        bus.core_req_valid_o = bus.req_valid_i & ~stall;
        bus.core_ready_o     = bus.dcache_ready_i & ~stall;
        send     = bus.req_valid_i & ~stall & bus.dcache_ready_i;
        recv_ok  = bus.rsp_valid_i & pending_q[bus.rsp_tag_i];
        spurious = bus.rsp_valid_i & ~pending_q[bus.rsp_tag_i];
    end

    // Next pending table, counter and watchdog.
    always_comb begin
        pending_d = pending_q;
        if (recv_ok) begin
            pending_d[bus.rsp_tag_i] = 1'b0;
        end
        // A send in the same cycle as a spurious response for the same tag still sets pending.
        if (send) begin
            pending_d[bus.req_tag_i] = 1'b1;
        end
        cnt_ext = {1'b0, cnt_q} + (CNT_W + 1)'(send) - (CNT_W + 1)'(recv_ok);
        cnt_d   = cnt_ext[CNT_W-1:0];
        wdog_d  = wdog_q;
        if ((cnt_q == '0) || recv_ok) begin
            wdog_d = '0;
        end else if (wdog_q != WD_W'(TIMEOUT_CYCLES)) begin
            wdog_d = wdog_q + WD_W'(1);
        end
    end

    // Table, counter, watchdog and sticky error flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= '0;
            cnt_q     <= '0;
            wdog_q    <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            wdog_q    <= wdog_d;
            err_q     <= err_q | spurious;
            timeout_q <= timeout_q | (wdog_d == WD_W'(TIMEOUT_CYCLES));
        end
    end

    // Fence FSM; the done pulse is registered on entry to StDone.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            fence_done_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    fence_done_q <= 1'b0;
                    if (bus.fence_i) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if ((cnt_d == '0) && bus.wbuf_empty_i) begin
                        state_q      <= StDone;
                        fence_done_q <= 1'b1;
                    end
                end
                StDone: begin
                    state_q      <= StIdle;
                    fence_done_q <= 1'b0;
                end
                default: begin
                    state_q      <= StIdle;
                    fence_done_q <= 1'b0;
                end
            endcase
        end
    end

    // Registered status outputs.
    always_comb begin
        bus.fence_done_o       = fence_done_q;
        bus.inflight_cnt_o     = cnt_q;
        bus.err_spurious_rsp_o = err_q;
        bus.timeout_o          = timeout_q;
    end
endmodule
